reg4_write_arbiter: RTL and testbench

Round-robin write arbiter owning a shared 4-bit register: up to NREQ requesters compete to load their 4-bit operand into the register through a req/gnt/ack handshake. Sits between producer blocks and the shared 4-bit storage register. Provides the registered value, current owner and a write counter to downstream logic.

---
 rtl/reg4_write_arbiter.sv | 141 ++++++++++++++
 tb/tb_reg4_write_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg4_write_arbiter.sv
// Round-robin write arbiter for a shared W-bit register (req/gnt/ack handshake).
// Define REG4ARB_LOCK_EN to add the lock port and back-to-back locked write runs.
module reg4_write_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   din,
`ifdef REG4ARB_LOCK_EN
    input  logic [NREQ-1:0]     lock,
`endif
    output logic [NREQ-1:0]     gnt,
    output logic                ack,
    output logic [W-1:0]        q,
    output logic [1:0]          owner,
    output logic                busy,
    output logic [7:0]          wcnt
);

    localparam int unsigned RUN_W   = 3;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(7);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [W-1:0]      q_q, q_d;
    logic [1:0]        owner_q, owner_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [RUN_W-1:0]  run_q, run_d;

    logic              found;
    logic [1:0]        winner;
    logic [1:0]        idx;
    logic              req_own;
    logic              lock_own;
    logic [W-1:0]      din_own;
    logic [1:0]        ptr_next;
    int                sum;

    // Owner-side views use the one-hot grant so no index is wider than the vectors.
    always_comb begin
        req_own = |(req & gnt_q);
`ifdef REG4ARB_LOCK_EN
        lock_own = |(lock & gnt_q);
`else
        lock_own = 1'b0;
`endif
        din_own = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_q[i]) din_own = din[i*int'(W) +: W];
        end
        ptr_next = (int'(owner_q) == int'(NREQ) - 1) ? 2'd0 : 2'(owner_q + 2'd1);
    end

    // Round-robin scan starting at ptr.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        sum    = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            sum = int'(ptr_q) + k;
            if (sum >= int'(NREQ)) sum = sum - int'(NREQ);
            idx = 2'(sum);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        q_d     = q_q;
        owner_d = owner_q;
        wcnt_d  = wcnt_q;
        run_d   = run_q;
        ack     = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    state_d = GRANT;
                    owner_d = winner;
                    run_d   = '0;
                    for (int i = 0; i < int'(NREQ); i++) gnt_d[i] = (int'(winner) == i);
                end
            end
            GRANT: begin
                state_d = IDLE;
                gnt_d   = '0;
                if (req_own) begin
                    ack    = 1'b1;
                    q_d    = din_own;
                    wcnt_d = wcnt_q + 8'd1;
                    ptr_d  = ptr_next;
                    // A locked owner keeps the grant until it has written 8 times in a row.
                    if (lock_own && run_q != RUN_LAST) begin
                        state_d = GRANT;
                        gnt_d   = gnt_q;
                        run_d   = run_q + RUN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            wcnt_q  <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            wcnt_q  <= wcnt_d;
            run_q   <= run_d;
        end
    end

    assign gnt   = gnt_q;
    assign q     = q_q;
    assign owner = owner_q;
    assign busy  = (state_q == GRANT);
    assign wcnt  = wcnt_q;

endmodule

// File: tb/tb_reg4_write_arbiter.sv
// Bench for reg4_write_arbiter: directed handshake scenarios plus randomized traffic
// against a transaction-level arbiter model. Lock scenario runs when REG4ARB_LOCK_EN is defined.
module tb_reg4_write_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 4;

    logic                clk = 1'b0;
    logic                clr;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   din;
`ifdef REG4ARB_LOCK_EN
    logic [NREQ-1:0]     lock;
`endif
    logic [NREQ-1:0]     gnt;
    logic                ack;
    logic [W-1:0]        q;
    logic [1:0]          owner;
    logic                busy;
    logic [7:0]          wcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg4_write_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .clr   (clr),
        .req   (req),
        .din   (din),
`ifdef REG4ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .owner (owner),
        .busy  (busy),
        .wcnt  (wcnt)
    );

    // Stimulus only: hold clr over two edges, release at a falling edge.
    task automatic apply_reset();
        clr = 1'b1;
        req = '0;
        din = '0;
`ifdef REG4ARB_LOCK_EN
        lock = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; req = '0; din = '0;
`ifdef REG4ARB_LOCK_EN
        lock = '0;
`endif
        @(posedge clk); @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want %b", gnt, 4'b0000); end
        checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_q got %h want %h", q, 4'h0); end
        checks++; if (wcnt !== 8'd0) begin errors++; $display("FAIL reset_wcnt got %0d want 0", wcnt); end
        checks++; if (owner !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_owner_busy got %0d/%b want 0/0", owner, busy); end
        clr = 1'b0;
        req = 4'b0001; din[3:0] = 4'hA;
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b1 || ack !== 1'b1) begin errors++; $display("FAIL reset_pre_grant got busy %b ack %b want 1 1", busy, ack); end
        clr = 1'b1; #1;
        checks++; if (gnt !== 4'b0000 || ack !== 1'b0) begin errors++; $display("FAIL reset_mid_grant got gnt %b ack %b want 0000 0", gnt, ack); end
        checks++; if (q !== 4'h0 || wcnt !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_state got q %h wcnt %0d busy %b want 0 0 0", q, wcnt, busy); end
        @(posedge clk); #1;
        checks++; if (q !== 4'h0) begin errors++; $display("FAIL reset_hold_q got %h want 0", q); end
        req = '0;
        @(negedge clk); clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (q !== 4'h0 || wcnt !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_after got q %h wcnt %0d busy %b want 0 0 0", q, wcnt, busy); end
    endtask

    task automatic test_single_write();
        apply_reset();
        req = 4'b0100; din[11:8] = 4'h9;
        @(posedge clk); @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want %b", gnt, 4'b0100); end
        checks++; if (ack !== 1'b1 || owner !== 2'd2) begin errors++; $display("FAIL single_ack_owner got %b/%0d want 1/2", ack, owner); end
        checks++; if (q !== 4'h0) begin errors++; $display("FAIL single_q_early got %h want 0", q); end
        @(posedge clk); #1;
        checks++; if (q !== 4'h9) begin errors++; $display("FAIL single_q got %h want 9", q); end
        checks++; if (wcnt !== 8'd1 || owner !== 2'd2) begin errors++; $display("FAIL single_wcnt_owner got %0d/%0d want 1/2", wcnt, owner); end
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release got gnt %b busy %b want 0000 0", gnt, busy); end
        req = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] e_gnt;
        apply_reset();
        din = {4'd4, 4'd3, 4'd2, 4'd1};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e_gnt = 4'(1 << (k % 4));
            @(posedge clk); #1;
            req = 4'b1111;
            @(negedge clk);
            checks++; if (gnt !== e_gnt || ack !== 1'b1) begin errors++; $display("FAIL rr_gnt%0d got %b ack %b want %b ack 1", k, gnt, ack, e_gnt); end
            @(posedge clk); #1;
            checks++; if (q !== 4'((k % 4) + 1)) begin errors++; $display("FAIL rr_q%0d got %h want %h", k, q, 4'((k % 4) + 1)); end
            req[k % 4] = 1'b0;
        end
        checks++; if (wcnt !== 8'd5) begin errors++; $display("FAIL rr_wcnt got %0d want 5", wcnt); end
        req = '0;
    endtask

    task automatic test_withdrawal();
        apply_reset();
        req = 4'b0010; din[7:4] = 4'h5; din[3:0] = 4'h3;
        @(posedge clk); #1;
        req = 4'b0000;
        @(negedge clk);
        checks++; if (ack !== 1'b0 || gnt !== 4'b0010) begin errors++; $display("FAIL wd_ack got ack %b gnt %b want 0 0010", ack, gnt); end
        @(posedge clk); #1;
        checks++; if (q !== 4'h0 || wcnt !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL wd_nowrite got q %h wcnt %0d busy %b want 0 0 0", q, wcnt, busy); end
        req = 4'b0011;
        @(posedge clk); @(negedge clk);
        checks++; if (gnt !== 4'b0001 || owner !== 2'd0) begin errors++; $display("FAIL wd_ptr got gnt %b owner %0d want 0001 0", gnt, owner); end
        @(posedge clk); #1;
        checks++; if (q !== 4'h3) begin errors++; $display("FAIL wd_q got %h want 3", q); end
        req = '0;
    endtask

    task automatic test_contention();
        apply_reset();
        req = 4'b1000; din[15:12] = 4'h7;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (q !== 4'h7 || owner !== 2'd3) begin errors++; $display("FAIL cont_first got q %h owner %0d want 7 3", q, owner); end
        req = 4'b1001; din[3:0] = 4'h2;
        @(posedge clk); @(negedge clk);
        checks++; if (gnt !== 4'b0001 || owner !== 2'd0) begin errors++; $display("FAIL cont_gnt got %b owner %0d want 0001 0", gnt, owner); end
        @(posedge clk); #1;
        checks++; if (q !== 4'h2 || wcnt !== 8'd2) begin errors++; $display("FAIL cont_q got q %h wcnt %0d want 2 2", q, wcnt); end
        req = '0;
    endtask

    // Randomized requesters against a transaction-level model of the arbiter.
    task automatic test_random();
        bit         m_busy = 1'b0;
        int         m_owner = 0;
        int         m_ptr = 0;
        logic [3:0] m_q = '0;
        int         m_wcnt = 0;
        logic [3:0] drop = '0;
        logic [3:0] e_gnt;
        logic       e_ack;
        int         idx;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (drop[i]) req[i] = 1'b0;
                else if (req[i] && $urandom_range(9) == 0) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(9) < 4) begin
                    req[i] = 1'b1;
                    din[i*int'(W) +: W] = W'($urandom);
                end
            end
            drop = '0;
            #1;
            e_gnt = m_busy ? 4'(1 << m_owner) : 4'b0000;
            e_ack = m_busy && req[m_owner];
            checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt c%0d got %b want %b", c, gnt, e_gnt); end
            checks++; if (ack !== e_ack) begin errors++; $display("FAIL rnd_ack c%0d got %b want %b", c, ack, e_ack); end
            checks++; if (q !== m_q || wcnt !== 8'(m_wcnt)) begin errors++; $display("FAIL rnd_q c%0d got q %h wcnt %0d want %h %0d", c, q, wcnt, m_q, m_wcnt); end
            checks++; if (owner !== 2'(m_owner) || busy !== m_busy) begin errors++; $display("FAIL rnd_owner c%0d got %0d/%b want %0d/%b", c, owner, busy, m_owner, m_busy); end
            if (m_busy) begin
                if (req[m_owner]) begin
                    m_q     = din[m_owner*int'(W) +: W];
                    m_wcnt  = (m_wcnt + 1) % 256;
                    m_ptr   = (m_owner + 1) % int'(NREQ);
                    drop[m_owner] = 1'b1;
                end
                m_busy = 1'b0;
            end else begin
                for (int k = 0; k < int'(NREQ); k++) begin
                    idx = (m_ptr + k) % int'(NREQ);
                    if (!m_busy && req[idx]) begin
                        m_busy  = 1'b1;
                        m_owner = idx;
                    end
                end
            end
            @(negedge clk);
        end
        req = '0;
    endtask

`ifdef REG4ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        lock = 4'b0010; req = 4'b0010; din[7:4] = 4'h6;
        @(posedge clk); #1;
        req = 4'b0011; din[3:0] = 4'h1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            checks++; if (ack !== 1'b1 || gnt !== 4'b0010) begin errors++; $display("FAIL lock_run%0d got ack %b gnt %b want 1 0010", n, ack, gnt); end
            @(posedge clk);
        end
        #1;
        checks++; if (wcnt !== 8'd8 || q !== 4'h6 || busy !== 1'b0) begin errors++; $display("FAIL lock_end got wcnt %0d q %h busy %b want 8 6 0", wcnt, q, busy); end
        @(posedge clk); @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL lock_next got %b want 0001", gnt); end
        req = '0; lock = '0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_withdrawal();
        test_contention();
        test_random();
`ifdef REG4ARB_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
